// File: rtl/uart_tx_drain_if.sv
// uart_tx_drain_if
// Read port of the upstream byte FIFO that feeds the UART transmitter.
//   fifo_empty   : FIFO holds no data (driven by the FIFO)
//   fifo_rd_data : registered read data, valid the cycle after a pop
//   fifo_rd_en   : one-cycle pop request (driven by the transmitter)
// The transmitter connects through the master modport; the FIFO side uses slave.
interface uart_tx_drain_if;
  logic       fifo_empty;
  logic [7:0] fifo_rd_data;
  logic       fifo_rd_en;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    input  fifo_rd_en
  );
endinterface

// File: rtl/uart_tx_drain.sv
// uart_tx_drain
// UART transmitter that drains an upstream byte FIFO. While enabled and the FIFO
// holds data it pops one byte, then serialises it as a frame:
//   start(0), 8 data bits LSB first, optional even parity, STOP_BITS stop bits(1).
// Back-to-back frames are separated by a 2-cycle high gap (pop + latch cycles).
// Ports:
//   clk        : clock, rising-edge
//   rst_n      : asynchronous active-low reset
//   i_enable   : allows a new frame to start (frames in flight always complete)
//   fifo       : uart_tx_drain_if.master (fifo_empty, fifo_rd_data, fifo_rd_en)
//   o_tx       : serial line, idles high
//   o_busy     : high in every state except IDLE
//   o_tx_done  : one-cycle pulse following the end of the final stop bit
module uart_tx_drain #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_enable,
  uart_tx_drain_if.master fifo,
  output logic            o_tx,
  output logic            o_busy,
  output logic            o_tx_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_LATCH  = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  // Counter is sized for the largest legal CLKS_PER_BIT (1023).
  localparam int                BAUD_W    = 10;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic              STOP_LAST = (STOP_BITS == 2);
  localparam bit                HAS_PAR   = (PARITY_EN != 0);

  state_t            r_state;
  state_t            w_next;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit;
  logic              r_stop;
  logic [7:0]        r_shift;
  logic              r_par;
  logic              r_done;

  logic              w_timed;
  logic              w_bit_end;
  logic              w_fetch;
  logic              w_stop_end;

  // States that occupy serial bit times and therefore run the baud counter.
  assign w_timed    = (r_state == S_START) || (r_state == S_DATA) ||
                      (r_state == S_PARITY) || (r_state == S_STOP);
  assign w_bit_end  = w_timed && (r_baud == BAUD_LAST);
  assign w_fetch    = i_enable && !fifo.fifo_empty;
  assign w_stop_end = (r_state == S_STOP) && w_bit_end && (r_stop == STOP_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_fetch) w_next = S_REQ;
      S_REQ:    w_next = S_LATCH;
      S_LATCH:  w_next = S_START;
      S_START:  if (w_bit_end) w_next = S_DATA;
      S_DATA: begin
        if (w_bit_end && (r_bit == 3'd7)) begin
          w_next = HAS_PAR ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (w_bit_end) w_next = S_STOP;
      // Chaining straight to REQ skips IDLE so the inter-frame gap is only the
      // pop and latch cycles.
      S_STOP:   if (w_stop_end) w_next = w_fetch ? S_REQ : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Baud counter, bit index and stop-bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud <= '0;
      r_bit  <= '0;
      r_stop <= 1'b0;
    end else begin
      if (!w_timed || w_bit_end) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + 1'b1;
      end

      // The 3-bit index wraps 7 -> 0 on the last data bit, leaving it ready
      // for the next frame.
      if (r_state != S_DATA) begin
        r_bit <= '0;
      end else if (w_bit_end) begin
        r_bit <= r_bit + 1'b1;
      end

      if (r_state != S_STOP) begin
        r_stop <= 1'b0;
      end else if (w_bit_end) begin
        r_stop <= r_stop + 1'b1;
      end
    end
  end

  // Shift register and parity. Parity is taken from the FIFO data at latch
  // time because the shift register is consumed while the data bits go out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_par   <= 1'b0;
    end else if (r_state == S_LATCH) begin
      r_shift <= fifo.fifo_rd_data;
      r_par   <= ^fifo.fifo_rd_data;
    end else if ((r_state == S_DATA) && w_bit_end) begin
      r_shift <= {1'b0, r_shift[7:1]};
    end
  end

  // Completion pulse, registered so it appears the cycle after the stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_stop_end;
    end
  end

  // Moore output decode
  always_comb begin
    o_tx = 1'b1;
    case (r_state)
      S_START:  o_tx = 1'b0;
      S_DATA:   o_tx = r_shift[0];
      S_PARITY: o_tx = r_par;
      default:  o_tx = 1'b1;
    endcase
  end

  assign o_busy          = (r_state != S_IDLE);
  assign o_tx_done       = r_done;
  assign fifo.fifo_rd_en = (r_state == S_REQ);

endmodule
